// File: rtl/gpa_fhdo_spi_master.sv
// -----------------------------------------------------------------------------
// gpa_fhdo_spi_master
//
// SPI initiator for the GPA-FHDO gradient board. Sends 24-bit DAC80504 write
// frames and, optionally, 32-bit ADS8684 readback frames over one shared
// sclk/sdo pair and one csn line. On the board, csn low selects the DAC and
// csn high selects the ADC, because the ADC chip-select is inverted.
//
// Optional feature macro: GPA_FHDO_READBACK_EN
//   defined   : ADC readback path present (ADC_PRE / ADC_XFER / ADC_POST).
//   undefined : adc_valid_i and fhdo_sdi are ignored, adc outputs tied to 0,
//               and only DAC frames are generated.
//
// Parameters:
//   SCLK_DIV : sclk half-period in clk cycles (1..255)
//   CS_GAP   : csn framing/idle time in clk cycles (1..255)
//
// Ports:
//   clk, rst_n        : system clock, asynchronous active-low reset
//   dac_word_i[23:0]  : DAC frame, MSB first ([23:16] cmd/addr, [15:0] data)
//   dac_valid_i       : DAC request (taken in IDLE, wins over adc_valid_i)
//   adc_cmd_i[15:0]   : ADS8684 command, shifted in the first 16 bits
//   adc_valid_i       : ADC readback request
//   busy_o            : transaction in progress, requests ignored while high
//   adc_data_o[15:0]  : last captured ADC result
//   adc_data_valid_o  : one-cycle strobe when adc_data_o updates
//   fhdo_sclk         : SPI clock, idle low
//   fhdo_csn          : chip select (low = DAC, high = ADC)
//   fhdo_sdo          : serial data to the board
//   fhdo_sdi          : serial data from the ADC
//
// Handshake: a request is taken on the clk edge where its valid is high while
// the block is IDLE; its input word is latched on that edge and busy_o rises
// the cycle after. Any valid seen while busy_o is high is ignored. A valid held
// high is taken again in the first IDLE cycle after busy_o falls.
// -----------------------------------------------------------------------------
module gpa_fhdo_spi_master #(
  parameter int unsigned SCLK_DIV = 2,
  parameter int unsigned CS_GAP   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] dac_word_i,
  input  logic        dac_valid_i,
  input  logic [15:0] adc_cmd_i,
  input  logic        adc_valid_i,
  output logic        busy_o,
  output logic [15:0] adc_data_o,
  output logic        adc_data_valid_o,
  output logic        fhdo_sclk,
  output logic        fhdo_csn,
  output logic        fhdo_sdo,
  input  logic        fhdo_sdi
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DAC_SETUP = 3'd1;
  localparam logic [2:0] S_DAC_XFER  = 3'd2;
  localparam logic [2:0] S_ADC_PRE   = 3'd3;
  localparam logic [2:0] S_ADC_XFER  = 3'd4;
  localparam logic [2:0] S_ADC_POST  = 3'd5;
  localparam logic [2:0] S_GAP       = 3'd6;

  // Counters count down to zero, so they load N-1 on state entry.
  localparam logic [7:0] DIV_LOAD = 8'(SCLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

  localparam logic [5:0] DAC_LAST_BIT = 6'd23;
  localparam logic [5:0] ADC_LAST_BIT = 6'd31;
  localparam logic [5:0] ADC_RX_FIRST = 6'd16;

  // Registered state
  logic [2:0]  state;
  logic [7:0]  gap_cnt;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic        phase_hi;   // 1 = first (sclk high) half of the current bit
  logic [31:0] shift_q;    // outgoing bits, MSB is on sdo

  // Next-state values
  logic [2:0]  state_n;
  logic [7:0]  gap_n;
  logic [7:0]  div_n;
  logic [5:0]  bit_n;
  logic        phase_n;
  logic [31:0] shift_n;
  logic        busy_n;
  logic        sclk_n;
  logic        csn_n;
  logic        sdo_n;
  logic        xfer_n;

`ifdef GPA_FHDO_READBACK_EN
  logic [15:0] rx_q;
  logic [15:0] rx_n;
  logic [15:0] adc_data_q;
  logic [15:0] adc_data_n;
  logic        adc_strobe_q;
  logic        adc_strobe_n;
`endif

  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    phase_n = phase_hi;
    shift_n = shift_q;
`ifdef GPA_FHDO_READBACK_EN
    rx_n         = rx_q;
    adc_data_n   = adc_data_q;
    adc_strobe_n = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (dac_valid_i) begin
          state_n = S_DAC_SETUP;
          gap_n   = GAP_LOAD;
          shift_n = {dac_word_i, 8'h00};
        end
`ifdef GPA_FHDO_READBACK_EN
        else if (adc_valid_i) begin
          state_n = S_ADC_PRE;
          gap_n   = GAP_LOAD;
          // Trailing zeros become the sdo value for bits 16..31.
          shift_n = {adc_cmd_i, 16'h0000};
        end
`endif
      end

      S_DAC_SETUP: begin
        if (gap_cnt == 8'd0) begin
          state_n = S_DAC_XFER;
          div_n   = DIV_LOAD;
          bit_n   = 6'd0;
          phase_n = 1'b1;
        end else begin
          gap_n = gap_cnt - 8'd1;
        end
      end

`ifdef GPA_FHDO_READBACK_EN
      // Zero-bit csn-low pulse; the DAC discards it, the ADC uses its
      // rising edge as the start of the frame.
      S_ADC_PRE: begin
        if (gap_cnt == 8'd0) begin
          state_n = S_ADC_XFER;
          div_n   = DIV_LOAD;
          bit_n   = 6'd0;
          phase_n = 1'b1;
        end else begin
          gap_n = gap_cnt - 8'd1;
        end
      end

      S_ADC_POST: begin
        if (gap_cnt == 8'd0) begin
          state_n = S_GAP;
          gap_n   = GAP_LOAD;
        end else begin
          gap_n = gap_cnt - 8'd1;
        end
      end
`endif

      S_DAC_XFER, S_ADC_XFER: begin
        if (div_cnt != 8'd0) begin
          div_n = div_cnt - 8'd1;
        end else if (phase_hi) begin
          // End of the high half: sclk falls on this edge, which is where
          // both the device and this block sample their inputs.
          phase_n = 1'b0;
          div_n   = DIV_LOAD;
`ifdef GPA_FHDO_READBACK_EN
          if ((state == S_ADC_XFER) && (bit_cnt >= ADC_RX_FIRST)) begin
            rx_n = {rx_q[14:0], fhdo_sdi};
          end
`endif
        end else if (bit_cnt == ((state == S_ADC_XFER) ? ADC_LAST_BIT : DAC_LAST_BIT)) begin
          gap_n = GAP_LOAD;
`ifdef GPA_FHDO_READBACK_EN
          if (state == S_ADC_XFER) begin
            state_n      = S_ADC_POST;
            adc_data_n   = rx_q;
            adc_strobe_n = 1'b1;
          end else begin
            state_n = S_GAP;
          end
`else
          state_n = S_GAP;
`endif
        end else begin
          bit_n   = bit_cnt + 6'd1;
          phase_n = 1'b1;
          div_n   = DIV_LOAD;
          shift_n = {shift_q[30:0], 1'b0};
        end
      end

      S_GAP: begin
        if (gap_cnt == 8'd0) begin
          state_n = S_IDLE;
        end else begin
          gap_n = gap_cnt - 8'd1;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Pin values are decoded from the next state so the pins come straight
    // out of flops and line up exactly with the state register.
    xfer_n = (state_n == S_DAC_XFER) || (state_n == S_ADC_XFER);
    sclk_n = xfer_n && phase_n;
    sdo_n  = xfer_n && shift_n[31];
    csn_n  = !((state_n == S_DAC_SETUP) || (state_n == S_DAC_XFER) ||
               (state_n == S_ADC_PRE)   || (state_n == S_ADC_POST));
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gap_cnt   <= 8'd0;
      div_cnt   <= 8'd0;
      bit_cnt   <= 6'd0;
      phase_hi  <= 1'b0;
      shift_q   <= 32'd0;
      busy_o    <= 1'b0;
      fhdo_sclk <= 1'b0;
      fhdo_csn  <= 1'b1;
      fhdo_sdo  <= 1'b0;
    end else begin
      state     <= state_n;
      gap_cnt   <= gap_n;
      div_cnt   <= div_n;
      bit_cnt   <= bit_n;
      phase_hi  <= phase_n;
      shift_q   <= shift_n;
      busy_o    <= busy_n;
      fhdo_sclk <= sclk_n;
      fhdo_csn  <= csn_n;
      fhdo_sdo  <= sdo_n;
    end
  end

`ifdef GPA_FHDO_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q         <= 16'h0000;
      adc_data_q   <= 16'h0000;
      adc_strobe_q <= 1'b0;
    end else begin
      rx_q         <= rx_n;
      adc_data_q   <= adc_data_n;
      adc_strobe_q <= adc_strobe_n;
    end
  end

  assign adc_data_o       = adc_data_q;
  assign adc_data_valid_o = adc_strobe_q;
`else
  // Readback path absent: its inputs are intentionally left unconsumed.
  logic unused_readback;
  assign unused_readback  = ^{adc_cmd_i, adc_valid_i, fhdo_sdi};
  assign adc_data_o       = 16'h0000;
  assign adc_data_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_gpa_fhdo_spi_master.sv
// -----------------------------------------------------------------------------
// tb_gpa_fhdo_spi_master
//
// Directed bench for gpa_fhdo_spi_master with SCLK_DIV=2, CS_GAP=4.
// Contains a DAC80504 model (shifts sdo on sclk falling edges while csn is low
// and updates vout0..3 on csn rising) and, when GPA_FHDO_READBACK_EN is
// defined, an ADS8684 model (frame while csn is high, drives sdi on sclk
// rising edges). Expected DAC frames and ADC results go into queues when
// requested and are popped when the models or the DUT produce them.
// -----------------------------------------------------------------------------
module tb_gpa_fhdo_spi_master;

  localparam int SCLK_DIV = 2;
  localparam int CS_GAP   = 4;
  localparam int DAC_LEN  = 2 * CS_GAP + 48 * SCLK_DIV;   // 104
  localparam int ADC_LEN  = 3 * CS_GAP + 64 * SCLK_DIV;   // 140

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] dac_word_i = 24'h0;
  logic        dac_valid_i = 1'b0;
  logic [15:0] adc_cmd_i = 16'h0;
  logic        adc_valid_i = 1'b0;
  logic        busy_o;
  logic [15:0] adc_data_o;
  logic        adc_data_valid_o;
  logic        fhdo_sclk;
  logic        fhdo_csn;
  logic        fhdo_sdo;
  logic        fhdo_sdi = 1'b0;

  always #5 clk = ~clk;

  gpa_fhdo_spi_master #(.SCLK_DIV(SCLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dac_word_i       (dac_word_i),
    .dac_valid_i      (dac_valid_i),
    .adc_cmd_i        (adc_cmd_i),
    .adc_valid_i      (adc_valid_i),
    .busy_o           (busy_o),
    .adc_data_o       (adc_data_o),
    .adc_data_valid_o (adc_data_valid_o),
    .fhdo_sclk        (fhdo_sclk),
    .fhdo_csn         (fhdo_csn),
    .fhdo_sdo         (fhdo_sdo),
    .fhdo_sdi         (fhdo_sdi)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [23:0] exp_q[$];      // expected DAC frames
  logic [15:0] adc_exp_q[$];  // expected ADC results

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- DAC80504 model ----------------
  logic [23:0] dac_sr = 24'h0;
  int          dac_bits = 0;
  int          last_dac_bits = 0;
  int          dac_frames = 0;
  int          aborted = 0;
  logic [15:0] vout[4];

  initial for (int i = 0; i < 4; i++) vout[i] = 16'h0;

  always @(negedge fhdo_sclk) begin
    if (fhdo_csn === 1'b0) begin
      dac_sr = {dac_sr[22:0], fhdo_sdo};
      dac_bits++;
    end
  end

  always @(negedge fhdo_csn) dac_bits = 0;

  always @(posedge fhdo_csn) begin
    if (dac_bits == 24) begin
      logic [23:0] e;
      last_dac_bits = dac_bits;
      dac_frames++;
      if (dac_sr[23:16] >= 8'h08 && dac_sr[23:16] <= 8'h0B)
        vout[dac_sr[17:16]] = dac_sr[15:0];
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
      chk("dac_frame", 32'(dac_sr), 32'(e));
    end else if (dac_bits != 0) begin
      aborted++;
    end
    dac_bits = 0;
  end

`ifdef GPA_FHDO_READBACK_EN
  // ---------------- ADS8684 model ----------------
  logic [15:0] ain_0p = 16'h0;
  logic [15:0] adc_cmd_rx = 16'h0;
  int          adc_bits = 0;
  int          last_adc_bits = 0;

  always @(posedge fhdo_csn) begin
    adc_bits   = 0;
    adc_cmd_rx = 16'h0;
  end

  always @(negedge fhdo_csn) last_adc_bits = adc_bits;

  always @(posedge fhdo_sclk) begin
    if (fhdo_csn === 1'b1)
      fhdo_sdi = (adc_bits >= 16) ? ain_0p[31 - adc_bits] : 1'b0;
  end

  always @(negedge fhdo_sclk) begin
    if (fhdo_csn === 1'b1) begin
      if (adc_bits < 16) adc_cmd_rx = {adc_cmd_rx[14:0], fhdo_sdo};
      adc_bits++;
    end
  end
`endif

  // ---------------- cycle monitors ----------------
  int busy_run = 0, last_busy_len = 0, busy_total = 0;
  int hi_run = 0, lo_run = 0, csn_low_total = 0, strobe_cnt = 0;
  int hi_log[$];
  int lo_log[$];

  always @(negedge clk) begin
    if (busy_o === 1'b1) begin
      busy_run++;
      busy_total++;
    end else if (busy_run > 0) begin
      last_busy_len = busy_run;
      busy_run = 0;
    end
    if (fhdo_csn === 1'b1) begin
      hi_run++;
      if (lo_run > 0) lo_log.push_back(lo_run);
      lo_run = 0;
    end else begin
      lo_run++;
      csn_low_total++;
      if (hi_run > 0) hi_log.push_back(hi_run);
      hi_run = 0;
    end
    if (adc_data_valid_o === 1'b1) begin
      logic [15:0] e;
      strobe_cnt++;
      e = (adc_exp_q.size() > 0) ? adc_exp_q.pop_front() : 16'hxxxx;
      chk("adc_data", 32'(adc_data_o), 32'(e));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_busy(input logic lvl, input int max, input string tag);
    int n = 0;
    while (busy_o !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy_o), 32'(lvl));
  endtask

  task automatic send_dac(input logic [23:0] w);
    @(negedge clk);
    dac_word_i  = w;
    dac_valid_i = 1'b1;
    exp_q.push_back(w);
    @(negedge clk);
    dac_valid_i = 1'b0;
    wait_busy(1'b0, 400, "dac_done");
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'(0));
    chk({tag, "_sclk"}, 32'(fhdo_sclk), 32'(0));
    chk({tag, "_csn"},  32'(fhdo_csn), 32'(1));
    chk({tag, "_sdo"},  32'(fhdo_sdo), 32'(0));
    chk({tag, "_adc_data"},  32'(adc_data_o), 32'(0));
    chk({tag, "_adc_valid"}, 32'(adc_data_valid_o), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int s0;
    logic [23:0] w;

    // Reset values
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single DAC frame
    send_dac(24'h08ABCD);
    chk("dac_vout0", 32'(vout[0]), 32'h0000ABCD);
    chk("dac_sclk_pulses", 32'(last_dac_bits), 32'd24);
    chk("dac_busy_len", 32'(last_busy_len), 32'(DAC_LEN));
    chk("dac_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of DAC_XFER
    @(negedge clk);
    dac_word_i  = 24'h095555;
    dac_valid_i = 1'b1;
    @(negedge clk);
    dac_valid_i = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst_busy_before", 32'(busy_o), 32'(1));
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy_total = 0;
    repeat (150) @(negedge clk);
    chk("midrst_no_resume", 32'(busy_total), 32'd0);
    chk("midrst_aborted", 32'(aborted), 32'd1);
    chk("midrst_vout1", 32'(vout[1]), 32'd0);
    chk("midrst_frames", 32'(dac_frames), 32'd1);

    // Back-to-back with dac_valid_i held high
    hi_log.delete();
    @(negedge clk);
    dac_word_i  = 24'h081111;
    dac_valid_i = 1'b1;
    exp_q.push_back(24'h081111);
    wait_busy(1'b1, 10, "b2b_x_start");
    dac_word_i = 24'h092222;
    exp_q.push_back(24'h092222);
    wait_busy(1'b0, 400, "b2b_x_done");
    wait_busy(1'b1, 10, "b2b_y_start");
    dac_word_i = 24'h0A3333;
    exp_q.push_back(24'h0A3333);
    wait_busy(1'b0, 400, "b2b_y_done");
    wait_busy(1'b1, 10, "b2b_z_start");
    dac_valid_i = 1'b0;
    wait_busy(1'b0, 400, "b2b_z_done");
    repeat (2) @(negedge clk);
    chk("b2b_vout0", 32'(vout[0]), 32'h1111);
    chk("b2b_vout1", 32'(vout[1]), 32'h2222);
    chk("b2b_vout2", 32'(vout[2]), 32'h3333);
    chk("b2b_gap_count", 32'(hi_log.size()), 32'd3);
    if (hi_log.size() == 3) begin
      chk("b2b_gap_xy", 32'(hi_log[1]), 32'(CS_GAP + 1));
      chk("b2b_gap_yz", 32'(hi_log[2]), 32'(CS_GAP + 1));
    end
    chk("b2b_q_empty", 32'(exp_q.size()), 32'd0);

    // Collision: DAC wins, ADC request dropped
    s0 = strobe_cnt;
    @(negedge clk);
    dac_word_i  = 24'h0B4444;
    adc_cmd_i   = 16'hC000;
    dac_valid_i = 1'b1;
    adc_valid_i = 1'b1;
    exp_q.push_back(24'h0B4444);
    @(negedge clk);
    dac_valid_i = 1'b0;
    adc_valid_i = 1'b0;
    wait_busy(1'b0, 400, "coll_done");
    repeat (20) @(negedge clk);
    chk("coll_vout3", 32'(vout[3]), 32'h4444);
    chk("coll_busy_len", 32'(last_busy_len), 32'(DAC_LEN));
    chk("coll_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    chk("coll_busy_after", 32'(busy_o), 32'd0);

`ifdef GPA_FHDO_READBACK_EN
    // ADC readback, two result patterns
    for (int k = 0; k < 2; k++) begin
      s0 = strobe_cnt;
      lo_log.delete();
      @(negedge clk);
      ain_0p    = (k == 0) ? 16'h1234 : 16'($urandom_range(0, 16'hFFFF));
      adc_cmd_i = (k == 0) ? 16'hC000 : 16'hC400;
      adc_exp_q.push_back(ain_0p);
      adc_valid_i = 1'b1;
      @(negedge clk);
      adc_valid_i = 1'b0;
      wait_busy(1'b0, 600, "adc_done");
      repeat (2) @(negedge clk);
      chk("adc_strobe_once", 32'(strobe_cnt - s0), 32'd1);
      chk("adc_data_hold", 32'(adc_data_o), 32'(ain_0p));
      chk("adc_sclk_pulses", 32'(last_adc_bits), 32'd32);
      chk("adc_cmd_rx", 32'(adc_cmd_rx), 32'(adc_cmd_i));
      chk("adc_busy_len", 32'(last_busy_len), 32'(ADC_LEN));
      chk("adc_low_pulses", 32'(lo_log.size()), 32'd2);
      if (lo_log.size() == 2) begin
        chk("adc_pre_len", 32'(lo_log[0]), 32'(CS_GAP));
        chk("adc_post_len", 32'(lo_log[1]), 32'(CS_GAP));
      end
      chk("adc_q_empty", 32'(adc_exp_q.size()), 32'd0);
    end
`else
    // Readback compiled out: adc_valid_i must have no effect
    s0 = strobe_cnt;
    busy_total = 0;
    csn_low_total = 0;
    @(negedge clk);
    adc_cmd_i   = 16'hC000;
    adc_valid_i = 1'b1;
    @(negedge clk);
    adc_valid_i = 1'b0;
    repeat (60) @(negedge clk);
    chk("noadc_busy", 32'(busy_total), 32'd0);
    chk("noadc_csn", 32'(csn_low_total), 32'd0);
    chk("noadc_strobe", 32'(strobe_cnt - s0), 32'd0);
    chk("noadc_data", 32'(adc_data_o), 32'd0);
`endif

    // Randomised DAC writes
    for (int k = 0; k < 4; k++) begin
      w = {8'(8 + $urandom_range(0, 3)), 16'($urandom_range(0, 16'hFFFF))};
      send_dac(w);
      chk("rand_vout", 32'(vout[w[17:16]]), 32'(w[15:0]));
      chk("rand_busy_len", 32'(last_busy_len), 32'(DAC_LEN));
    end

    repeat (5) @(negedge clk);
    chk("final_dac_q_empty", 32'(exp_q.size()), 32'd0);
    chk("final_idle", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
